uart_rx: RTL and testbench

//   UART receiver, counterpart to uart_tx: 8N1 frames, LSB first, idle-high line.

---
 rtl/uart_rx_if.sv | 33 +++
 rtl/uart_rx.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Signal bundle between the UART receiver and its byte
//                consumer: serial line in, received byte and status strobes out.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_if;
  logic       rx;          // serial line, asynchronous, idles high
  logic [7:0] data;        // last correctly framed byte
  logic       rx_done;     // 1-cycle strobe: data updated
  logic       err;         // 1-cycle strobe: framing error
  logic       parity_err;  // 1-cycle strobe: parity mismatch

  // Receiver side: consumes the line, produces byte and strobes
  modport master (
    input  rx,
    output data,
    output rx_done,
    output err,
    output parity_err
  );

  // Pad / consumer side: drives the line, observes byte and strobes
  modport slave (
    output rx,
    input  data,
    input  rx_done,
    input  err,
    input  parity_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver, 8N1 LSB first, idle-high line. Two-flop
//                synchroniser, start-bit qualification at half a bit, mid-bit
//                sampling, 1-cycle rx_done / err / parity_err strobes.
//                Optional feature macro: UART_RX_PARITY_EN (8E1 framing with
//                an extra PARITY state and a parity_err strobe).
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  wire logic clk,
  input  wire logic rst,      // asynchronous, active-low
  uart_rx_if.master bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
      $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end
  endgenerate

`ifdef UART_RX_PARITY_EN
  localparam int ST_W = 5;
`else
  localparam int ST_W = 4;
`endif

  // One-hot state encoding, one bit per state
  typedef enum logic [ST_W-1:0] {
    IDLE   = ST_W'(1) << 0,
    START  = ST_W'(1) << 1,
    RX     = ST_W'(1) << 2,
    STOP   = ST_W'(1) << 3
`ifdef UART_RX_PARITY_EN
    ,
    PARITY = ST_W'(1) << 4
`endif
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             rx_done_q, rx_done_d;
  logic             err_q, err_d;
  // Set once the line has been seen high since the last frame; a start is only
  // taken on a fresh high->low transition, so a held-low break yields one err.
  logic             armed_q, armed_d;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
  logic             parity_err_q, parity_err_d;
`endif

  logic rx_s;
  assign rx_s = sync2_q;

  // Two-flop synchroniser for the asynchronous rx pin (idles high)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.rx;
      sync2_q <= sync1_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      rx_done_q    <= 1'b0;
      err_q        <= 1'b0;
      armed_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      rx_done_q    <= rx_done_d;
      err_q        <= err_d;
      armed_q      <= armed_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state, counters, shift register and strobe generation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    rx_done_d    = 1'b0;
    err_d        = 1'b0;
    armed_d      = armed_q;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        armed_d = armed_q | rx_s;
        if (armed_q && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
          armed_d = 1'b0;
        end
      end

      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = RX;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;   // glitch shorter than half a bit
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RX: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            // Stop bit high: line is idle, a start may follow immediately
            armed_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            if ((^shift_q) == par_q) begin
              data_d    = shift_q;
              rx_done_d = 1'b1;
            end else begin
              parity_err_d = 1'b1;
            end
`else
            data_d    = shift_q;
            rx_done_d = 1'b1;
`endif
          end else begin
            err_d   = 1'b1;
            armed_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.data    = data_q;
  assign bus.rx_done = rx_done_q;
  assign bus.err     = err_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx at 4 clocks per bit. A
//                frame-level model predicts each strobe (kind, byte, arrival
//                window) and the held data byte.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;
  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 12_500_000;
  localparam int C        = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif
  localparam int LAT     = 2 + C / 2 + NBITS * C + 2;
  localparam int LAT_MIN = LAT - 2;
  localparam int LAT_MAX = LAT + 1;

  localparam int K_DONE = 0;
  localparam int K_ERR  = 1;
  localparam int K_PERR = 2;

  typedef struct {
    int         kind;
    logic [7:0] b;
    int         t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  uart_rx_if bus ();

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t       expq[$];
  logic [7:0] model_data = 8'h00;
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int perr_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    bus.rx = v;
    step(C);
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    step(n);
  endtask

  // Send one frame and record what the receiver must report for it
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    exp_t e;
    e.b = b;
    e.t = cyc;
    if (!stop_bit) e.kind = K_ERR;
`ifdef UART_RX_PARITY_EN
    else if (par_bit != ^b) e.kind = K_PERR;
`endif
    else e.kind = K_DONE;
    expq.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`else
    if (par_bit === 1'bx) $display("parity bit unused");
`endif
    drive_bit(stop_bit);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b1, ^b);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && expq.size() > 0; i++) step(1);
  endtask

  // Compare process: every cycle check strobes against the model queue and
  // the held byte against the model's last good byte
  initial begin : compare
    bit   prev_str;
    int   ns, kind_act, lat;
    exp_t e;
    prev_str = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("reset_outputs", int'({bus.data, bus.rx_done, bus.err, bus.parity_err}), 0);
        prev_str = 1'b0;
      end else begin
        ns = int'(bus.rx_done) + int'(bus.err) + int'(bus.parity_err);
        if (ns > 0) begin
          done_cnt += int'(bus.rx_done);
          err_cnt  += int'(bus.err);
          perr_cnt += int'(bus.parity_err);
          chk("strobe_exclusive", ns, 1);
          chk("strobe_back_to_back", int'(prev_str), 0);
          kind_act = bus.rx_done ? K_DONE : (bus.err ? K_ERR : K_PERR);
          if (expq.size() == 0) begin
            chk("unexpected_strobe", ns, 0);
          end else begin
            e = expq.pop_front();
            chk("strobe_kind", kind_act, e.kind);
            lat = cyc - e.t;
            n_checks++;
            if (lat < LAT_MIN || lat > LAT_MAX) begin
              n_errors++;
              $display("FAIL latency: got %0d cycles required %0d..%0d", lat, LAT_MIN, LAT_MAX);
            end
            if (e.kind == K_DONE) model_data = e.b;
          end
        end
        chk("data_hold", int'(bus.data), int'(model_data));
        if (expq.size() > 0 && (cyc - expq[0].t) > LAT_MAX) begin
          n_checks++;
          n_errors++;
          $display("FAIL missing_strobe: got none required kind %0d byte 0x%0h", expq[0].kind, expq[0].b);
          void'(expq.pop_front());
        end
        prev_str = (ns > 0);
      end
    end
  end

  // Stimulus
  initial begin : stim
    int         base;
    logic [7:0] b;
    logic       stop_bit, par_bit;
    logic [7:0] v3c;

    bus.rx = 1'b1;
    rst    = 1'b0;
    step(3);
    rst = 1'b1;
    step(4);

    // Reset state
    chk("t1_data", int'(bus.data), 0);
    chk("t1_rx_done", int'(bus.rx_done), 0);
    chk("t1_err", int'(bus.err), 0);
    chk("t1_parity_err", int'(bus.parity_err), 0);

    // Single good frame
    send_good(8'h48);
    idle(6);
    drain();
    chk("t2_data", int'(bus.data), 'h48);
    chk("t2_done_count", done_cnt, 1);

    // One-cycle glitch must not start a frame
    base   = done_cnt + err_cnt + perr_cnt;
    bus.rx = 1'b0;
    step(1);
    idle(20);
    chk("t3_no_strobe", done_cnt + err_cnt + perr_cnt - base, 0);

    // Framing error keeps old data, next frame recovers
    send_frame(8'h5A, 1'b0, 1'b0);
    idle(6);
    drain();
    chk("t4_err_count", err_cnt, 1);
    chk("t4_data_kept", int'(bus.data), 'h48);
    send_good(8'h21);
    idle(6);
    drain();
    chk("t4_data_next", int'(bus.data), 'h21);

    // Held-low break gives a single err
    send_frame(8'h00, 1'b0, 1'b0);
    bus.rx = 1'b0;
    step(40);
    idle(10);
    drain();
    chk("break_single_err", err_cnt, 2);

    // Back-to-back frames, no idle gap
    base = done_cnt;
    send_good(8'h55);
    send_good(8'hAA);
    idle(6);
    drain();
    chk("t5_done_count", done_cnt - base, 2);
    chk("t5_data", int'(bus.data), 'hAA);

    // Reset in the middle of bit 4
    v3c = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(v3c[i]);
    bus.rx = v3c[4];
    step(2);
    rst        = 1'b0;
    bus.rx     = 1'b1;
    model_data = 8'h00;
    #1;
    chk("t6_reset_data", int'(bus.data), 0);
    chk("t6_reset_strobes", int'({bus.rx_done, bus.err, bus.parity_err}), 0);
    step(3);
    rst = 1'b1;
    idle(5);
    base = done_cnt + err_cnt + perr_cnt;
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(6);
    drain();
    chk("t6_one_strobe", done_cnt + err_cnt + perr_cnt - base, 1);
`ifdef UART_RX_PARITY_EN
    chk("t6_parity_data", int'(bus.data), 0);
    chk("t6_parity_err_count", perr_cnt, 1);
`else
    chk("t6_data", int'(bus.data), 'h3C);
`endif

    // Randomized frames: random bytes, gaps, framing and parity errors
    for (int n = 0; n < 40; n++) begin
      b        = 8'($urandom);
      stop_bit = ($urandom_range(0, 5) != 0);
      par_bit  = (^b) ^ ($urandom_range(0, 4) == 0);
      send_frame(b, stop_bit, par_bit);
      if (!stop_bit) idle($urandom_range(3, 8));
      else           idle($urandom_range(0, 6));
    end
    idle(10);
    drain();
    chk("final_queue_empty", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
